// File: rtl/backprop_sequencer.sv
// Backward-pass initiator: buffers forward activations, then walks layers top-down driving the backpropagator.
// Optional watchdog on the completion wait is enabled with `define BP_SEQ_TIMEOUT_EN.
module backprop_sequencer #(
  parameter int NEURON_NUM          = 5,
  parameter int NEURON_OUTPUT_WIDTH = 10,
  parameter int WEIGHT_CELL_WIDTH   = 16,
  parameter int LAYER_ADDR_WIDTH    = 2,
  parameter int LAYER_MAX           = 3,
  parameter int SAMPLE_ADDR_SIZE    = 10,
  parameter int TIMEOUT_CYCLES      = 4096
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 z_wr_en,
  input  logic [LAYER_ADDR_WIDTH:0]                            z_wr_addr,
  input  logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0]            z_wr_data,
  input  logic                                                 train_start,
  input  logic [SAMPLE_ADDR_SIZE-1:0]                          sample_in,
  output logic                                                 bp_start,
  output logic [LAYER_ADDR_WIDTH-1:0]                          bp_layer,
  output logic [SAMPLE_ADDR_SIZE-1:0]                          bp_sample,
  output logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0]            bp_z,
  output logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0]            bp_z_prev,
  input  logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0]   bp_weights,
  input  logic                                                 bp_valid,
  input  logic                                                 bp_error,
  output logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0]   weights_out,
  output logic [LAYER_ADDR_WIDTH-1:0]                          weights_layer,
  output logic                                                 weights_valid,
  output logic                                                 busy,
  output logic                                                 done,
  output logic                                                 error,
  output logic [1:0]                                           state_dbg
);

  localparam int ZW = NEURON_NUM * NEURON_OUTPUT_WIDTH;
  localparam logic [LAYER_ADDR_WIDTH-1:0] TOP_LAYER = LAYER_ADDR_WIDTH'(LAYER_MAX - 1);
  localparam logic [LAYER_ADDR_WIDTH-1:0] TOP_Z     = LAYER_ADDR_WIDTH'(LAYER_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [ZW-1:0]   zbuf [0:LAYER_MAX];
  logic [LAYER_MAX:0] z_mask;
  logic            bp_valid_q;
  logic            completion;
  logic            timed_out;
  logic            abort;

  // Handshake: bp_start pulses for one cycle with layer/sample/z operands already stable;
  // they hold until the next bp_start. The backpropagator answers by raising bp_valid
  // (a level that may linger between passes); only its 0->1 transition while waiting
  // counts as completion, and bp_weights must be valid on that rising cycle.
  assign completion = bp_valid & ~bp_valid_q;
  assign state_dbg  = state;

`ifdef BP_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != S_WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timed_out = (state == S_WAIT) && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  // An error during a pass wins over a coincident completion edge.
  assign abort = ((state == S_ISSUE) || (state == S_WAIT)) && (bp_error || timed_out);

  // Activation storage has no reset; the mask tracks which boundaries are valid.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && z_wr_en) begin
      for (int i = 0; i <= LAYER_MAX; i++) begin
        if (z_wr_addr == (LAYER_ADDR_WIDTH + 1)'(i)) begin
          zbuf[i] <= z_wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      z_mask        <= '0;
      bp_valid_q    <= 1'b0;
      bp_start      <= 1'b0;
      bp_layer      <= '0;
      bp_sample     <= '0;
      bp_z          <= '0;
      bp_z_prev     <= '0;
      weights_out   <= '0;
      weights_layer <= '0;
      weights_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      bp_valid_q    <= bp_valid;
      bp_start      <= 1'b0;
      weights_valid <= 1'b0;
      done          <= 1'b0;

      if (state == S_IDLE && z_wr_en) begin
        for (int i = 0; i <= LAYER_MAX; i++) begin
          if (z_wr_addr == (LAYER_ADDR_WIDTH + 1)'(i)) begin
            z_mask[i] <= 1'b1;
          end
        end
      end

      case (state)
        S_IDLE: begin
          if (train_start) begin
            if (&z_mask) begin
              bp_sample <= sample_in;
              bp_layer  <= TOP_LAYER;
              bp_z      <= zbuf[TOP_Z];
              bp_z_prev <= zbuf[TOP_LAYER];
              bp_start  <= 1'b1;
              error     <= 1'b0;
              busy      <= 1'b1;
              state     <= S_ISSUE;
            end else begin
              error <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          if (abort) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (abort) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (completion) begin
            weights_out   <= bp_weights;
            weights_layer <= bp_layer;
            weights_valid <= 1'b1;
            if (bp_layer == '0) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              // bp_layer still names the finished layer, so its z_prev is the next pass's z.
              bp_layer  <= bp_layer - 1'b1;
              bp_z      <= zbuf[bp_layer];
              bp_z_prev <= zbuf[bp_layer - 1'b1];
              bp_start  <= 1'b1;
              state     <= S_ISSUE;
            end
          end
        end

        S_DONE: begin
          z_mask <= '0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_backprop_sequencer.sv
// Self-checking bench for backprop_sequencer: vector table, directed corner sequences and randomized runs
// checked against a layer-walk reference model with a stub backpropagator.
module tb_backprop_sequencer;

  localparam int NN   = 5;
  localparam int OW   = 10;
  localparam int CW   = 16;
  localparam int LW   = 2;
  localparam int LMAX = 3;
  localparam int SW   = 10;
  localparam int TO   = 16;
  localparam int ZW   = NN * OW;
  localparam int WW   = NN * NN * CW;
  localparam int IW   = LW + SW + 2 * ZW;

  logic            clk;
  logic            rst;
  logic            z_wr_en;
  logic [LW:0]     z_wr_addr;
  logic [ZW-1:0]   z_wr_data;
  logic            train_start;
  logic [SW-1:0]   sample_in;
  logic            bp_start;
  logic [LW-1:0]   bp_layer;
  logic [SW-1:0]   bp_sample;
  logic [ZW-1:0]   bp_z;
  logic [ZW-1:0]   bp_z_prev;
  logic [WW-1:0]   bp_weights = '0;
  logic            bp_valid = 1'b0;
  logic            bp_error;
  logic [WW-1:0]   weights_out;
  logic [LW-1:0]   weights_layer;
  logic            weights_valid;
  logic            busy;
  logic            done;
  logic            error;
  logic [1:0]      state_dbg;

  backprop_sequencer #(
    .NEURON_NUM(NN), .NEURON_OUTPUT_WIDTH(OW), .WEIGHT_CELL_WIDTH(CW),
    .LAYER_ADDR_WIDTH(LW), .LAYER_MAX(LMAX), .SAMPLE_ADDR_SIZE(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .z_wr_en(z_wr_en), .z_wr_addr(z_wr_addr), .z_wr_data(z_wr_data),
    .train_start(train_start), .sample_in(sample_in), .bp_start(bp_start), .bp_layer(bp_layer),
    .bp_sample(bp_sample), .bp_z(bp_z), .bp_z_prev(bp_z_prev), .bp_weights(bp_weights),
    .bp_valid(bp_valid), .bp_error(bp_error), .weights_out(weights_out),
    .weights_layer(weights_layer), .weights_valid(weights_valid), .busy(busy), .done(done),
    .error(error), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- shared bench state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int n_start  = 0;
  int n_wv     = 0;
  int n_done   = 0;

  logic [ZW-1:0]   mdl_z [0:LMAX];
  logic [IW-1:0]   exp_q[$];
  logic [IW-1:0]   obs_i_q[$];
  logic [LW+WW-1:0] obs_w_q[$];
  logic [WW-1:0]   resp_w_q[$];

  int rsp_delay = 5;
  int rsp_drop  = 0;
  bit rsp_pulse = 1'b1;
  bit rsp_en    = 1'b1;
  int rise_cd   = -1;
  int drop_cd   = -1;

  function automatic logic [ZW-1:0] rand_z();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[ZW-1:0];
  endfunction

  function automatic logic [WW-1:0] rand_w();
    logic [415:0] r;
    for (int i = 0; i < 13; i++) r[i*32 +: 32] = $urandom;
    return r[WW-1:0];
  endfunction

  // Stub backpropagator: rises rsp_delay cycles after bp_start; in level mode it
  // keeps valid high until rsp_drop cycles after the following bp_start.
  always @(negedge clk) begin
    if (rst) begin
      rise_cd  = -1;
      drop_cd  = -1;
      bp_valid = 1'b0;
    end else begin
      if (rsp_pulse && bp_valid) bp_valid = 1'b0;
      if (bp_start && rsp_en) begin
        rise_cd = rsp_delay;
        drop_cd = rsp_drop;
      end else begin
        if (rise_cd > 0) rise_cd--;
        if (drop_cd > 0) drop_cd--;
      end
      if (drop_cd == 0) begin
        bp_valid = 1'b0;
        drop_cd  = -1;
      end
      if (rise_cd == 0) begin
        bp_weights = rand_w();
        bp_valid   = 1'b1;
        resp_w_q.push_back(bp_weights);
        rise_cd    = -1;
      end
    end
  end

  // Event recorder feeding the scoreboard.
  always @(negedge clk) begin
    if (bp_start) begin
      n_start++;
      obs_i_q.push_back({bp_layer, bp_sample, bp_z, bp_z_prev});
    end
    if (weights_valid) begin
      n_wv++;
      obs_w_q.push_back({weights_layer, weights_out});
    end
    if (done) n_done++;
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_z(input int addr, input logic [ZW-1:0] data, input bit upd);
    z_wr_en   = 1'b1;
    z_wr_addr = (LW + 1)'(addr);
    z_wr_data = data;
    tick();
    z_wr_en   = 1'b0;
    if (upd && addr <= LMAX) mdl_z[addr] = data;
  endtask

  task automatic load_random();
    for (int a = 0; a <= LMAX; a++) write_z(a, rand_z(), 1'b1);
  endtask

  task automatic start_run(input logic [SW-1:0] s);
    train_start = 1'b1;
    sample_in   = s;
    tick();
    train_start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {bp_start, bp_layer, bp_sample, bp_z, bp_z_prev, weights_layer,
                           weights_valid, busy, done, error}, '0);
    check({tag, "_weights"}, weights_out, '0);
  endtask

  // Full run against the reference model: passes go top layer down to 0, each pairing
  // boundary l+1 with boundary l, and each capture returns the stub's weights for that layer.
  task automatic run_checked(input string tag, input logic [SW-1:0] s, input bit junk);
    int d0;
    int w0;
    int nexp;
    d0 = n_done;
    w0 = n_wv;
    exp_q.delete();
    obs_i_q.delete();
    obs_w_q.delete();
    resp_w_q.delete();
    for (int l = LMAX - 1; l >= 0; l--) exp_q.push_back({LW'(l), s, mdl_z[l+1], mdl_z[l]});
    start_run(s);
    check({tag, "_start_latency"}, bp_start, 1'b1);
    check({tag, "_error_cleared"}, error, 1'b0);
    check({tag, "_busy_on"}, busy, 1'b1);
    for (int i = 0; i < 2000 && n_done == d0; i++) begin
      if (junk && i == 2) write_z($urandom_range(0, LMAX), rand_z(), 1'b0);
      else if (junk && i == 4) start_run(~s);
      else tick();
    end
    check({tag, "_done_count"}, n_done - d0, 1);
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_done_pulse_ended"}, done, 1'b0);
    check({tag, "_error_after"}, error, 1'b0);
    check({tag, "_issue_count"}, obs_i_q.size(), exp_q.size());
    nexp = (obs_i_q.size() < exp_q.size()) ? obs_i_q.size() : exp_q.size();
    for (int i = 0; i < nexp; i++) check($sformatf("%s_issue%0d", tag, i), obs_i_q[i], exp_q[i]);
    check({tag, "_capture_count"}, n_wv - w0, LMAX);
    check({tag, "_stub_rises"}, resp_w_q.size(), LMAX);
    for (int i = 0; i < LMAX && i < obs_w_q.size() && i < resp_w_q.size(); i++)
      check($sformatf("%s_capture%0d", tag, i), obs_w_q[i], {LW'(LMAX - 1 - i), resp_w_q[i]});
  endtask

  task automatic wait_layer1_wait(input string tag, input int s0);
    for (int i = 0; i < 300 && n_start - s0 < 2; i++) tick();
    check({tag, "_reached_layer1"}, n_start - s0, 2);
  endtask

  typedef struct {
    logic [3:0] wmask;
    bit         oor;
    bit         exp_err;
    bit         exp_start;
  } vec_t;

  vec_t vecs[6];

  // ---------------- test sequence ----------------
  initial begin
    int s0;
    int w0;
    int d0;
    rst = 1'b1; z_wr_en = 1'b0; z_wr_addr = '0; z_wr_data = '0;
    train_start = 1'b0; sample_in = '0; bp_error = 1'b0;

    do_reset();
    check_reset_outputs("reset");

    // Mask completeness table: which boundaries get written, plus an out-of-range write.
    vecs[0] = '{4'b1111, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{4'b0111, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{4'b1110, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{4'b1011, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{4'b0000, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{4'b1101, 1'b1, 1'b1, 1'b0};
    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int a = 0; a <= LMAX; a++) if (vecs[v].wmask[a]) write_z(a, rand_z(), 1'b1);
      if (vecs[v].oor) write_z(4 + $urandom_range(0, 3), rand_z(), 1'b0);
      start_run(SW'(v + 1));
      check($sformatf("vec%0d_error", v), error, vecs[v].exp_err);
      check($sformatf("vec%0d_bp_start", v), bp_start, vecs[v].exp_start);
      check($sformatf("vec%0d_busy", v), busy, vecs[v].exp_start);
    end

    // Directed run: A..D, sample 7, stub answers 5 cycles after each start.
    do_reset();
    rsp_pulse = 1'b1; rsp_delay = 5; rsp_drop = 0;
    write_z(0, 50'h0_0000_0000_0AAA, 1'b1);
    write_z(1, 50'h0_0000_0000_0BBB, 1'b1);
    write_z(2, 50'h0_0000_0000_0CCC, 1'b1);
    write_z(3, 50'h0_0000_0000_0DDD, 1'b1);
    run_checked("basic", 10'd7, 1'b0);
    check("basic_last_layer", weights_layer, 2'd0);

    // Stale-high valid: level stub drops 2 cycles after bp_start, rises at 5.
    rsp_pulse = 1'b0; rsp_delay = 5; rsp_drop = 2;
    load_random();
    run_checked("stale_a", 10'd100, 1'b0);
    check("stale_valid_left_high", bp_valid, 1'b1);
    load_random();
    run_checked("stale_b", 10'd101, 1'b0);

    // Incomplete mask, then completion of the mask lets a run proceed.
    do_reset();
    rsp_pulse = 1'b1; rsp_delay = 4; rsp_drop = 0;
    for (int a = 0; a < LMAX; a++) write_z(a, rand_z(), 1'b1);
    s0 = n_start;
    start_run(10'd3);
    check("partial_error", error, 1'b1);
    check("partial_no_start", bp_start, 1'b0);
    tick(); tick();
    check("partial_busy", busy, 1'b0);
    check("partial_start_count", n_start - s0, 0);
    write_z(LMAX, rand_z(), 1'b1);
    run_checked("completed_mask", 10'd3, 1'b0);

    // bp_error during the layer-1 wait aborts the run.
    load_random();
    rsp_delay = 10;
    s0 = n_start; w0 = n_wv; d0 = n_done;
    start_run(10'd5);
    wait_layer1_wait("abort", s0);
    bp_error = 1'b1;
    tick();
    bp_error = 1'b0;
    check("abort_error", error, 1'b1);
    check("abort_busy", busy, 1'b0);
    repeat (20) tick();
    check("abort_no_more_starts", n_start - s0, 2);
    check("abort_no_done", n_done - d0, 0);
    check("abort_captures", n_wv - w0, 1);
    check("abort_weights_layer", weights_layer, 2'd2);

    // Reset mid-run clears everything including the activation mask.
    do_reset();
    rsp_delay = 6;
    load_random();
    s0 = n_start;
    start_run(10'd9);
    wait_layer1_wait("midrst", s0);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    s0 = n_start;
    start_run(10'd9);
    check("midrst_restart_error", error, 1'b1);
    check("midrst_restart_no_start", bp_start, 1'b0);
    tick();
    check("midrst_restart_busy", busy, 1'b0);
    check("midrst_start_count", n_start - s0, 0);

    // Randomized runs with writes and starts injected while busy.
    for (int r = 0; r < 6; r++) begin
      rsp_pulse = 1'($urandom_range(0, 1));
      rsp_delay = $urandom_range(2, 8);
      rsp_drop  = $urandom_range(0, rsp_delay - 1);
      load_random();
      run_checked($sformatf("rand%0d", r), SW'($urandom_range(0, 1023)), 1'b1);
    end

`ifdef BP_SEQ_TIMEOUT_EN
    // Watchdog: stub silent, abort 16 cycles after entering WAIT.
    do_reset();
    rsp_en = 1'b0;
    load_random();
    start_run(10'd11);
    tick();
    repeat (TO - 1) tick();
    check("timeout_busy_before", busy, 1'b1);
    check("timeout_error_before", error, 1'b0);
    tick();
    check("timeout_busy_after", busy, 1'b0);
    check("timeout_error_after", error, 1'b1);
    rsp_en = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
